// File: rtl/dbg_pkg.sv
// dbg_pkg: command codes, FSM states and result constants shared by the debug module and core responder.
package dbg_pkg;
  localparam logic [7:0] DBG_CMD_HALT   = 8'h01;
  localparam logic [7:0] DBG_CMD_RESUME = 8'h02;
  localparam logic [7:0] DBG_CMD_RD_REG = 8'h03;
  localparam logic [7:0] DBG_CMD_WR_REG = 8'h04;
  localparam logic [7:0] DBG_CMD_RD_PC  = 8'h05;
  localparam logic [7:0] DBG_CMD_WR_PC  = 8'h06;
  localparam logic [31:0] DBG_HALT_TIMEOUT_RES = 32'h1;
  typedef enum logic [2:0] {
    ST_IDLE, ST_HALT_WAIT, ST_RESUME_WAIT, ST_RF_READ, ST_RF_WRITE, ST_PC_WRITE, ST_DONE
  } dbg_state_t;
endpackage

// File: rtl/dbg_intf.sv
// dbg_intf: command/response bus between the system debug module and a core responder.
interface dbg_intf;
  logic [7:0]  cmd;
  logic [31:0] addr;
  logic [31:0] data_dbg_dut;
  logic [31:0] data_dut_dbg;
  logic        dut_done;
  modport dut (input cmd, addr, data_dbg_dut, output data_dut_dbg, dut_done);
  modport dbg (output cmd, addr, data_dbg_dut, input data_dut_dbg, dut_done);
endinterface

// File: rtl/core_dbg_module.sv
// core_dbg_module: core-side debug responder for halt/resume, register-file and PC access.
module core_dbg_module
  import dbg_pkg::*;
#(
  parameter int HALT_TIMEOUT = 1024,
  parameter int RF_RD_LAT    = 1
) (
  input  logic        clk,
  input  logic        rstn_i,
  dbg_intf.dut        dbg_bus,
  output logic        halt_o,
  input  logic        core_halted_i,
  output logic [4:0]  rf_addr_o,
  input  logic [31:0] rf_rdata_i,
  output logic        rf_we_o,
  output logic [31:0] rf_wdata_o,
  input  logic [31:0] if_pc_i,
  output logic        pc_set_o,
  output logic [31:0] pc_o,
  output logic        flush_o
);
  // one counter serves both the halt/resume timeout and the register-read latency
  localparam int CNT_MAX = HALT_TIMEOUT > RF_RD_LAT ? HALT_TIMEOUT : RF_RD_LAT;
  localparam int CW = CNT_MAX > 0 ? $clog2(CNT_MAX + 1) : 1;
  dbg_state_t state;
  logic [CW-1:0] cnt;
  logic done_q;
  logic [31:0] data_q;
  logic [7:0] cmd;
  logic [4:0] addr;
  logic halted_ok, wait_ok, timeout;
  logic unused_addr;
  assign cmd = dbg_bus.cmd;
  assign addr = dbg_bus.addr[4:0];
  assign unused_addr = ^dbg_bus.addr[31:5];
  assign halted_ok = halt_o & core_halted_i;
  assign wait_ok = (state == ST_HALT_WAIT) ? core_halted_i : !core_halted_i;
  assign timeout = HALT_TIMEOUT != 0 && cnt == CW'(HALT_TIMEOUT - 1);
  assign dbg_bus.dut_done = done_q;
  assign dbg_bus.data_dut_dbg = data_q;
  always_ff @(posedge clk or negedge rstn_i)
    if (!rstn_i) begin
      state <= ST_IDLE;
      cnt <= '0;
      done_q <= 1'b0;
      data_q <= '0;
      halt_o <= 1'b0;
      rf_addr_o <= '0;
      rf_we_o <= 1'b0;
      rf_wdata_o <= '0;
      pc_set_o <= 1'b0;
      pc_o <= '0;
      flush_o <= 1'b0;
    end else begin
      done_q <= 1'b0;
      data_q <= '0;
      rf_we_o <= 1'b0;
      pc_set_o <= 1'b0;
      flush_o <= 1'b0;
      case (state)
        ST_IDLE: if (cmd != 8'h00) begin
          cnt <= '0;
          if (cmd == DBG_CMD_HALT) begin
            halt_o <= 1'b1;
            state <= ST_HALT_WAIT;
          end else if (cmd == DBG_CMD_RESUME) begin
            halt_o <= 1'b0;
            state <= ST_RESUME_WAIT;
          end else if (halted_ok && cmd == DBG_CMD_RD_REG) begin
            rf_addr_o <= addr;
            state <= ST_RF_READ;
          end else if (halted_ok && cmd == DBG_CMD_WR_REG) begin
            rf_addr_o <= addr;
            rf_wdata_o <= dbg_bus.data_dbg_dut;
            rf_we_o <= addr != 5'd0;
            state <= ST_RF_WRITE;
          end else if (halted_ok && cmd == DBG_CMD_RD_PC) begin
            data_q <= if_pc_i;
            done_q <= 1'b1;
            state <= ST_DONE;
          end else if (halted_ok && cmd == DBG_CMD_WR_PC) begin
            pc_o <= dbg_bus.data_dbg_dut;
            pc_set_o <= 1'b1;
            flush_o <= 1'b1;
            state <= ST_PC_WRITE;
          end else begin
            done_q <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_HALT_WAIT, ST_RESUME_WAIT:
          if (wait_ok || timeout) begin
            data_q <= wait_ok ? 32'h0 : DBG_HALT_TIMEOUT_RES;
            done_q <= 1'b1;
            state <= ST_DONE;
          end else cnt <= cnt + 1'b1;
        ST_RF_READ:
          if (cnt == CW'(RF_RD_LAT)) begin
            data_q <= rf_rdata_i;
            done_q <= 1'b1;
            state <= ST_DONE;
          end else cnt <= cnt + 1'b1;
        ST_RF_WRITE, ST_PC_WRITE: begin
          done_q <= 1'b1;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_core_dbg_module.sv
// tb_core_dbg_module: directed scoreboard bench for core_dbg_module with a small core/register-file model.
module tb_core_dbg_module;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  dbg_intf bus();
  logic halt_o, core_halted, rf_we, pc_set, flush;
  logic [4:0] rf_addr;
  logic [31:0] rf_rdata, rf_wdata, pc;
  logic [31:0] if_pc = 32'h0000_0100;
  logic [7:0] cmd_r = 8'h00;
  logic live = 1'b0, stuck = 1'b0;
  logic [2:0] hist = 3'b000;
  logic [31:0] mem [32];
  logic [31:0] sb_q [$];
  logic [31:0] exp_d, pc_seen;
  logic h1;
  int passed = 0, total = 0;
  int cyc, we_n, set_n, fl_n, co_n;

  core_dbg_module #(.HALT_TIMEOUT(8), .RF_RD_LAT(1)) dut (
    .clk(clk), .rstn_i(rstn), .dbg_bus(bus.dut), .halt_o(halt_o), .core_halted_i(core_halted),
    .rf_addr_o(rf_addr), .rf_rdata_i(rf_rdata), .rf_we_o(rf_we), .rf_wdata_o(rf_wdata),
    .if_pc_i(if_pc), .pc_set_o(pc_set), .pc_o(pc), .flush_o(flush)
  );

  // initiator drops cmd combinationally while dut_done is high
  assign bus.cmd = bus.dut_done ? 8'h00 : cmd_r;
  // core reports halted three cycles after halt_o changes, unless frozen
  assign core_halted = live ? hist[2] : stuck;

  always @(posedge clk) begin
    hist <= {hist[1:0], halt_o};
    if (!rstn) for (int i = 0; i < 32; i++) mem[i] <= '0;
    else if (rf_we) mem[rf_addr] <= rf_wdata;
    rf_rdata <= mem[rf_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk)
    if (bus.dut_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL spurious_done: dut_done=1 with no command outstanding");
      end else begin
        exp_d = sb_q.pop_front();
        check("data_dut_dbg", bus.data_dut_dbg, exp_d);
      end
    end

  task automatic send(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d, input logic [31:0] ed);
    @(negedge clk);
    sb_q.push_back(ed);
    bus.addr = a;
    bus.data_dbg_dut = d;
    cmd_r = c;
    cyc = 0; we_n = 0; set_n = 0; fl_n = 0; co_n = 0; pc_seen = '0; h1 = 1'b0;
    while (cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        h1 = halt_o;
        bus.addr = ~a;
        bus.data_dbg_dut = ~d;
      end
      we_n += int'(rf_we);
      set_n += int'(pc_set);
      fl_n += int'(flush);
      co_n += int'(pc_set & flush);
      if (pc_set) pc_seen = pc;
      if (bus.dut_done) break;
    end
    cmd_r = 8'h00;
  endtask

  initial begin
    bus.addr = '0;
    bus.data_dbg_dut = '0;
    repeat (2) @(negedge clk);
    check("reset halt_o", halt_o, 0);
    check("reset dut_done", bus.dut_done, 0);
    check("reset data", bus.data_dut_dbg, 0);
    check("reset strobes", {rf_we, pc_set, flush}, 0);
    rstn = 1'b1;
    live = 1'b1;
    send(8'h04, 32'd5, 32'h1234, 32'h0);
    check("guard wr latency", cyc, 1);
    check("guard wr no we", we_n, 0);
    send(8'h03, 32'd5, 32'h0, 32'h0);
    check("guard rd latency", cyc, 1);
    send(8'h06, 32'h0, 32'h200, 32'h0);
    check("guard pc no set", set_n, 0);
    send(8'h7F, 32'h0, 32'h0, 32'h0);
    check("unknown latency", cyc, 1);
    live = 1'b0;
    stuck = 1'b0;
    send(8'h01, 32'h0, 32'h0, 32'h1);
    check("halt timeout latency", cyc, 9);
    check("halt_o after accept", h1, 1);
    check("halt_o after timeout", halt_o, 1);
    live = 1'b1;
    send(8'h02, 32'h0, 32'h0, 32'h0);
    check("resume latency", cyc, 5);
    check("halt_o after resume", halt_o, 0);
    send(8'h01, 32'h0, 32'h0, 32'h0);
    check("halt latency", cyc, 5);
    check("halt_o cycle after accept", h1, 1);
    send(8'h01, 32'h0, 32'h0, 32'h0);
    check("re-halt latency", cyc, 2);
    send(8'h04, 32'd5, 32'hCAFE_BABE, 32'h0);
    check("wr latency", cyc, 2);
    check("wr one we", we_n, 1);
    send(8'h03, 32'd5, 32'h0, 32'hCAFE_BABE);
    check("rd latency", cyc, 3);
    send(8'h04, 32'd0, 32'hDEAD_BEEF, 32'h0);
    check("wr x0 no we", we_n, 0);
    check("wr x0 latency", cyc, 2);
    send(8'h03, 32'd0, 32'h0, 32'h0);
    send(8'h05, 32'h0, 32'h0, 32'h0000_0100);
    check("rd pc latency", cyc, 1);
    send(8'h06, 32'h0, 32'h0000_0200, 32'h0);
    check("pc_set count", set_n, 1);
    check("flush count", fl_n, 1);
    check("pc_set with flush", co_n, 1);
    check("pc_o value", pc_seen, 32'h0000_0200);
    check("wr pc latency", cyc, 2);
    check("pc_o holds", pc, 32'h0000_0200);
    live = 1'b0;
    stuck = 1'b0;
    @(negedge clk);
    bus.addr = '0;
    cmd_r = 8'h01;
    repeat (3) @(negedge clk);
    check("halt_o before reset", halt_o, 1);
    rstn = 1'b0;
    #1;
    check("reset mid halt halt_o", halt_o, 0);
    check("reset mid halt dut_done", bus.dut_done, 0);
    cmd_r = 8'h00;
    @(negedge clk);
    rstn = 1'b1;
    live = 1'b1;
    repeat (4) @(negedge clk);
    send(8'h02, 32'h0, 32'h0, 32'h0);
    check("resume after reset latency", cyc, 2);
    repeat (3) @(negedge clk);
    check("scoreboard drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/core_dbg_module.md
Name: core_dbg_module

Overview:
- Core-side responder on dbg_intf; executes the commands the system debug module issues.
- Operations: halt/resume the pipeline, read/write a register-file entry, read the IF-stage PC, set the PC with a pipeline flush.
- Sits inside the core top. It owns the core's debug register-file port and the PC-override/flush controls.
- Completes every accepted command with exactly one dut_done pulse, so the initiator never hangs.

Parameters:
- HALT_TIMEOUT, 1024: max cycles to wait for core_halted_i on halt or resume; 0 = wait forever.
- RF_RD_LAT, 1: register-file read latency in cycles (1 = synchronous read).

Ports:
- clk  in  1  core clock
- rstn_i  in  1  asynchronous active-low reset
- dbg_bus  dbg_intf.dut  -  responder side of dbg_intf:
  - inputs: cmd[7:0], addr[31:0], data_dbg_dut[31:0]
  - outputs: data_dut_dbg[31:0], dut_done
- halt_o  out  1  request the pipeline to stall and drain
- core_halted_i  in  1  core reports it is fully halted
- rf_addr_o  out  5  debug register-file address
- rf_rdata_i  in  32  debug register-file read data
- rf_we_o  out  1  debug register-file write enable
- rf_wdata_o  out  32  debug register-file write data
- if_pc_i  in  32  current IF-stage PC
- pc_set_o  out  1  one-cycle PC override strobe
- pc_o  out  32  PC override value
- flush_o  out  1  pipeline flush, coincident with pc_set_o

Behaviour:
- Reset (async, rstn_i low): state IDLE. All outputs 0, including halt_o (core runs), dut_done, data_dut_dbg, timeout counter, latched operands.
- Command codes: 0x01 halt, 0x02 resume, 0x03 read reg, 0x04 write reg, 0x05 read PC, 0x06 write PC. 0x00 = idle.
- Accept:
  - Only in IDLE with cmd != 0.
  - Latch cmd, addr[4:0] and data_dbg_dut on acceptance; later bus changes are ignored until done.
  - The initiator drops cmd to 0 combinationally while dut_done is high, so re-acceptance cannot occur in the DONE cycle.
- States: IDLE -> {HALT_WAIT, RESUME_WAIT, RF_READ, RF_WRITE, PC_WRITE, DONE} -> DONE -> IDLE.
- DONE: dut_done=1 for exactly one cycle; data_dut_dbg is registered and valid in that cycle, 0 otherwise. Back to IDLE next cycle.
- Halt (0x01):
  - halt_o set to 1 at acceptance and held until a resume completes.
  - HALT_WAIT counts cycles until core_halted_i=1, then DONE with data 0.
  - If the counter reaches HALT_TIMEOUT: DONE with data 1; halt_o stays 1.
  - Halt while already halted: core_halted_i is already 1, so done on the next cycle.
- Resume (0x02): halt_o cleared at acceptance. RESUME_WAIT until core_halted_i=0 (same timeout rule, data 1 on timeout), then DONE with data 0.
- Guard: commands 0x03–0x06 act only when halt_o=1 and core_halted_i=1. Otherwise they go directly to DONE with data 0 and no side effects.
- Read reg (0x03): drive rf_addr_o=addr[4:0]; wait RF_RD_LAT cycles; capture rf_rdata_i into data_dut_dbg; DONE. Latency from accept to dut_done = RF_RD_LAT+1.
- Write reg (0x04):
  - rf_we_o=1 for one cycle with rf_addr_o and rf_wdata_o from the latched values; then DONE.
  - addr=0 suppresses rf_we_o (x0 immutable) but still completes.
- Read PC (0x05): capture if_pc_i at acceptance; DONE next cycle.
- Write PC (0x06): pc_set_o=1, flush_o=1, pc_o=latched data for one cycle (PC_WRITE); DONE next cycle. pc_o is forced to 32'h0 when bit[1:0]!=0? No — pc_o is driven unmodified; alignment is the initiator's responsibility.
- Unknown command (0x07–0xFF): DONE next cycle with data 0.
- rf_addr_o, rf_wdata_o and pc_o hold their last value outside strobes; only rf_we_o, pc_set_o and flush_o are strobes.
- Reset mid-operation: abort to IDLE, no dut_done, halt_o released.

Decomposition:
- dbg_pkg (shared with the system debug module):
  - DBG_CMD_* localparams for the internal command codes 0x01–0x06.
  - dbg_state_t enum.
  - DBG_HALT_TIMEOUT_RES = 32'h1.
- Single module; no sub-module needed. The timeout counter is inline, clog2(HALT_TIMEOUT+1) bits.

Test Plan:
- Halt: cmd=0x01; core_halted_i rises 3 cycles later -> halt_o=1 from the cycle after accept; dut_done one pulse with data 0; no second pulse while cmd=0.
- Halt timeout: HALT_TIMEOUT=8, core_halted_i stuck 0 -> dut_done with data 1 after 8 wait cycles; halt_o remains 1.
- Register write/read while halted: write addr=5, data 32'hCAFEBABE -> rf_we_o one cycle; read addr=5 -> data_dut_dbg=32'hCAFEBABE with dut_done at accept+2. Write addr=0 -> no rf_we_o, dut_done pulses.
- PC: core halted, if_pc_i=32'h0000_0100; cmd=0x05 -> data 0x100. cmd=0x06, data 32'h0000_0200 -> pc_set_o=flush_o=1 one cycle, pc_o=0x200, then dut_done.
- Guard and unknown commands: core running, cmd=0x04 -> rf_we_o never asserted, dut_done with data 0. cmd=0x7F -> dut_done next cycle with data 0.
- Reset mid-halt: assert rstn_i low during HALT_WAIT -> halt_o=0 and dut_done=0 immediately; after release, next cmd=0x02 accepted normally.
